// File: rtl/exu_ctrl_if.sv
// Upstream (IDU) and downstream (WBU) handshake bundle for exu_ctrl.
// Holds the default datapath width macros shared by the controller and its users.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 8
`endif

interface exu_ctrl_if;
    logic                    i_idu_valid;
    logic                    o_idu_ready;
    logic [`ADDR_WIDTH-1:0]  i_idu_pc;
    logic [`DATA_WIDTH-1:0]  i_idu_rs1_data;
    logic [`DATA_WIDTH-1:0]  i_idu_rs2_data;
    logic [`DATA_WIDTH-1:0]  i_idu_jmp_or_reg_data;
    logic [`ARGS_WIDTH-1:0]  i_idu_ctr_alu_type;
    logic [`ARGS_WIDTH-1:0]  i_idu_ctr_jmp_type;
    logic [`ARGS_WIDTH-1:0]  i_idu_ctr_inst_type;
    logic                    o_wbu_valid;
    logic                    i_wbu_ready;
    logic [`DATA_WIDTH-1:0]  o_wbu_res;
    logic [`ADDR_WIDTH-1:0]  o_wbu_pc;

    modport master (
        output i_idu_valid, i_idu_pc, i_idu_rs1_data, i_idu_rs2_data,
               i_idu_jmp_or_reg_data, i_idu_ctr_alu_type, i_idu_ctr_jmp_type,
               i_idu_ctr_inst_type, i_wbu_ready,
        input  o_idu_ready, o_wbu_valid, o_wbu_res, o_wbu_pc
    );

    modport slave (
        input  i_idu_valid, i_idu_pc, i_idu_rs1_data, i_idu_rs2_data,
               i_idu_jmp_or_reg_data, i_idu_ctr_alu_type, i_idu_ctr_jmp_type,
               i_idu_ctr_inst_type, i_wbu_ready,
        output o_idu_ready, o_wbu_valid, o_wbu_res, o_wbu_pc
    );
endinterface

// File: rtl/exu_ctrl.sv
// Execute-stage sequencer: latch decoded instruction, capture datapath result, hand to WBU, redirect fetch.
// Define EXU_CTRL_PERF_EN to build the instruction/stall performance counters.
//
// state | meaning
// IDLE  | ready for a new instruction from IDU
// EXEC  | datapath evaluating the latched instruction (one cycle)
// DONE  | result presented to WBU, waiting for ready
// FLUSH | post-redirect bubble, FLUSH_CYC cycles
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 8
`endif

module exu_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int WDOG_MAX  = 255
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    input  logic                   i_sys_flush,
    exu_ctrl_if.slave              bus,
    output logic [`ADDR_WIDTH-1:0] o_exu_pc,
    output logic [`DATA_WIDTH-1:0] o_exu_rs1_data,
    output logic [`DATA_WIDTH-1:0] o_exu_rs2_data,
    output logic [`DATA_WIDTH-1:0] o_exu_jmp_or_reg_data,
    output logic [`ARGS_WIDTH-1:0] o_exu_ctr_alu_type,
    output logic [`ARGS_WIDTH-1:0] o_exu_ctr_jmp_type,
    output logic [`ARGS_WIDTH-1:0] o_exu_ctr_inst_type,
    input  logic [`DATA_WIDTH-1:0] i_exu_res,
    input  logic                   i_exu_jmp_en,
    input  logic [`ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                   o_ifu_redir_en,
    output logic [`ADDR_WIDTH-1:0] o_ifu_redir_pc,
    output logic                   o_err_wdog,
    output logic [31:0]            o_perf_inst_cnt,
    output logic [31:0]            o_perf_stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_FLUSH} state_t;

    localparam logic [15:0] WDOG_TC  = 16'(WDOG_MAX);
    localparam logic [3:0]  FLUSH_LD = 4'(FLUSH_CYC - 1);

    state_t                 state_q;
    logic                   idu_ready_q;
    logic [`ADDR_WIDTH-1:0] exu_pc_q;
    logic [`DATA_WIDTH-1:0] exu_rs1_q;
    logic [`DATA_WIDTH-1:0] exu_rs2_q;
    logic [`DATA_WIDTH-1:0] exu_jr_q;
    logic [`ARGS_WIDTH-1:0] exu_alu_q;
    logic [`ARGS_WIDTH-1:0] exu_jmp_q;
    logic [`ARGS_WIDTH-1:0] exu_inst_q;
    logic                   jmp_en_q;
    logic                   wbu_valid_q;
    logic [`DATA_WIDTH-1:0] wbu_res_q;
    logic [`ADDR_WIDTH-1:0] wbu_pc_q;
    logic                   redir_en_q;
    logic [`ADDR_WIDTH-1:0] redir_pc_q;
    logic [3:0]             flush_cnt_q;
    logic [15:0]            wdog_q;
    logic                   err_wdog_q;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q     <= S_IDLE;
            idu_ready_q <= 1'b1;
            exu_pc_q    <= '0;
            exu_rs1_q   <= '0;
            exu_rs2_q   <= '0;
            exu_jr_q    <= '0;
            exu_alu_q   <= '0;
            exu_jmp_q   <= '0;
            exu_inst_q  <= '0;
            jmp_en_q    <= 1'b0;
            wbu_valid_q <= 1'b0;
            wbu_res_q   <= '0;
            wbu_pc_q    <= '0;
            redir_en_q  <= 1'b0;
            redir_pc_q  <= '0;
            flush_cnt_q <= '0;
            wdog_q      <= '0;
            err_wdog_q  <= 1'b0;
        end else if (i_sys_flush) begin
            // Abort: a captured-but-unshown redirect is dropped along with the result.
            state_q     <= S_IDLE;
            idu_ready_q <= 1'b1;
            jmp_en_q    <= 1'b0;
            wbu_valid_q <= 1'b0;
            redir_en_q  <= 1'b0;
            wdog_q      <= '0;
        end else begin
            redir_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_idu_valid) begin
                        exu_pc_q    <= bus.i_idu_pc;
                        exu_rs1_q   <= bus.i_idu_rs1_data;
                        exu_rs2_q   <= bus.i_idu_rs2_data;
                        exu_jr_q    <= bus.i_idu_jmp_or_reg_data;
                        exu_alu_q   <= bus.i_idu_ctr_alu_type;
                        exu_jmp_q   <= bus.i_idu_ctr_jmp_type;
                        exu_inst_q  <= bus.i_idu_ctr_inst_type;
                        idu_ready_q <= 1'b0;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wbu_res_q   <= i_exu_res;
                    wbu_pc_q    <= exu_pc_q;
                    wbu_valid_q <= 1'b1;
                    jmp_en_q    <= i_exu_jmp_en;
                    redir_en_q  <= i_exu_jmp_en;
                    redir_pc_q  <= i_exu_jmp_pc;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.i_wbu_ready) begin
                        wbu_valid_q <= 1'b0;
                        wdog_q      <= '0;
                        if (jmp_en_q) begin
                            flush_cnt_q <= FLUSH_LD;
                            state_q     <= S_FLUSH;
                        end else begin
                            idu_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end else if (wdog_q != WDOG_TC) begin
                        wdog_q <= wdog_q + 16'd1;
                        if (wdog_q + 16'd1 == WDOG_TC)
                            err_wdog_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        jmp_en_q    <= 1'b0;
                        idu_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    idu_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_idu_ready      = idu_ready_q;
    assign bus.o_wbu_valid      = wbu_valid_q;
    assign bus.o_wbu_res        = wbu_res_q;
    assign bus.o_wbu_pc         = wbu_pc_q;
    assign o_exu_pc             = exu_pc_q;
    assign o_exu_rs1_data       = exu_rs1_q;
    assign o_exu_rs2_data       = exu_rs2_q;
    assign o_exu_jmp_or_reg_data = exu_jr_q;
    assign o_exu_ctr_alu_type   = exu_alu_q;
    assign o_exu_ctr_jmp_type   = exu_jmp_q;
    assign o_exu_ctr_inst_type  = exu_inst_q;
    assign o_ifu_redir_en       = redir_en_q;
    assign o_ifu_redir_pc       = redir_pc_q;
    assign o_err_wdog           = err_wdog_q;

`ifdef EXU_CTRL_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_stall_q;

    // A handshake in the same cycle as a flush does not retire the instruction.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (!i_sys_flush && state_q == S_DONE && bus.i_wbu_ready)
                perf_inst_q <= perf_inst_q + 32'd1;
            if (bus.i_idu_valid && !idu_ready_q)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign o_perf_inst_cnt  = perf_inst_q;
    assign o_perf_stall_cnt = perf_stall_q;
`else
    assign o_perf_inst_cnt  = 32'd0;
    assign o_perf_stall_cnt = 32'd0;
`endif

endmodule
